// File: rtl/serial_deser_pkg.sv
// Shared types and constants for serial_word_deserializer.
// The PARITY state exists only when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;
  localparam int DEFAULT_WIDTH = 8;

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} deserState_e;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} deserState_e;
`endif
endpackage

// File: rtl/deser_bit_counter.sv
// Bit index counter for the deserializer: load to 1 on start of frame,
// clear when a frame completes, increment per accepted bit.
module deser_bit_counter
  import serial_deser_pkg::*;
#(
  parameter int N  = DEFAULT_WIDTH,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_terminal
);

  logic [CW-1:0] r_count;

  // Load wins over clear so a restarting sof always begins a fresh frame at index 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(1);
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == CW'(N - 1));

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word deserializer with one-word output slot and overrun flag.
// Optional even-parity bit after the data bits when SERIAL_DESER_PARITY_EN is defined.
module serial_word_deserializer
  import serial_deser_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         sof,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         overrun,
  input  logic         clr_overrun,
  output logic         aborted,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

  deserState_e   r_state;
  deserState_e   w_nextState;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  w_nextShift;
  logic [N-1:0]  w_assembled;
  logic [N-1:0]  r_wordOut;
  logic          r_wordValid;
  logic          r_overrun;
  logic          r_aborted;
  logic [CW-1:0] w_count;
  logic          w_terminal;
  logic          w_start;
  logic          w_accept;
  logic          w_complete;
  logic          w_slotFree;

  assign w_start    = bit_valid && sof;
  assign w_accept   = bit_valid && !sof && (r_state == SHIFT);
  assign w_slotFree = !r_wordValid || word_ready;

  deser_bit_counter #(.N(N), .CW(CW)) u_bitCounter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start),
    .i_clear    (w_complete),
    .i_inc      (w_accept),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_nextState = SHIFT;
      end
      SHIFT: begin
        if (w_start) begin
          w_nextState = SHIFT;
        end else if (w_accept && w_terminal) begin
`ifdef SERIAL_DESER_PARITY_EN
          w_nextState = PARITY;
`else
          w_nextState = IDLE;
          w_complete  = 1'b1;
`endif
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      PARITY: begin
        if (w_start) begin
          w_nextState = SHIFT;
        end else if (bit_valid) begin
          w_nextState = IDLE;
          w_complete  = 1'b1;
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  // The word including the bit arriving this cycle, so completion can load it immediately.
  always_comb begin
    w_nextShift = r_shift;
    if (w_start) begin
      w_nextShift[0] = bit_in;
    end else if (w_accept) begin
      for (int i = 0; i < N; i++) begin
        if (w_count == CW'(i)) w_nextShift[i] = bit_in;
      end
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  logic w_parityErr;
  logic r_parityErr;

  assign w_assembled = r_shift;
  assign w_parityErr = ^{r_shift, bit_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parityErr <= 1'b0;
    end else if (w_complete && w_slotFree) begin
      r_parityErr <= w_parityErr;
    end
  end

  assign parity_err = r_parityErr;
`else
  assign w_assembled = w_nextShift;
  assign parity_err  = 1'b0;
`endif

  // A blocked slot drops the new word and raises overrun; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_wordOut   <= '0;
      r_wordValid <= 1'b0;
      r_overrun   <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_shift   <= w_nextShift;
      r_aborted <= w_start && (r_state != IDLE);
      if (w_complete && w_slotFree) begin
        r_wordOut   <= w_assembled;
        r_wordValid <= 1'b1;
      end else if (r_wordValid && word_ready) begin
        r_wordValid <= 1'b0;
      end
      if (w_complete && !w_slotFree) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign word_out   = r_wordOut;
  assign word_valid = r_wordValid;
  assign overrun    = r_overrun;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer (N=8); covers the parity bit
// when compiled with SERIAL_DESER_PARITY_EN.
module tb_serial_word_deserializer;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         bit_in;
  logic         bit_valid;
  logic         sof;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         overrun;
  logic         clr_overrun;
  logic         aborted;
  logic         parity_err;

  int           vectorCount = 0;
  int           missCount   = 0;
  logic [8:0]   sbQueue[$];

  serial_word_deserializer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .sof         (sof),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .aborted     (aborted),
    .parity_err  (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBit(input logic b, input logic s);
    bit_in    = b;
    sof       = s;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic sendDataBits(input logic [N-1:0] data, input int gapMax);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gapMax)) idleCycle();
      driveBit(data[i], i == 0);
    end
  endtask

  task automatic sendFrame(input logic [N-1:0] data, input int gapMax);
    sendDataBits(data, gapMax);
`ifdef SERIAL_DESER_PARITY_EN
    driveBit(^data, 1'b0);
`endif
  endtask

  // Every handshake seen at the falling edge must match the oldest expected word.
  initial begin
    logic [8:0] expWord;
    forever begin
      @(negedge clk);
      if (reset && word_valid && word_ready) begin
        checkOutput("sbNonEmpty", sbQueue.size() != 0, 1);
        if (sbQueue.size() != 0) begin
          expWord = sbQueue.pop_front();
          checkOutput("sbWord", word_out, expWord[N-1:0]);
          checkOutput("sbParity", parity_err, expWord[8]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] data;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    sof         = 1'b0;
    word_ready  = 1'b0;
    clr_overrun = 1'b0;
    reset       = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("rstWord", word_out, 0);
    checkOutput("rstValid", word_valid, 0);
    checkOutput("rstOverrun", overrun, 0);
    checkOutput("rstAborted", aborted, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idleCycle();

    word_ready = 1'b1;
    sbQueue.push_back({1'b0, 8'hA5});
    sendFrame(8'hA5, 0);
    checkOutput("a5Valid", word_valid, 1);
    checkOutput("a5Word", word_out, 8'hA5);
    idleCycle();
    checkOutput("a5Pulse", word_valid, 0);

    sbQueue.push_back({1'b0, 8'h5A});
    sendFrame(8'h5A, 3);
    checkOutput("gapValid", word_valid, 1);
    checkOutput("gapWord", word_out, 8'h5A);
    idleCycle();
    checkOutput("gapPulse", word_valid, 0);

    word_ready = 1'b0;
    sbQueue.push_back({1'b0, 8'h3C});
    sendFrame(8'h3C, 1);
    checkOutput("ovrFirstValid", word_valid, 1);
    checkOutput("ovrFirstFlag", overrun, 0);
    sendFrame(8'h81, 1);
    checkOutput("ovrFlag", overrun, 1);
    checkOutput("ovrKeepWord", word_out, 8'h3C);
    clr_overrun = 1'b1;
    idleCycle();
    clr_overrun = 1'b0;
    checkOutput("ovrCleared", overrun, 0);
    checkOutput("ovrHeldValid", word_valid, 1);
    word_ready = 1'b1;
    idleCycle();
    checkOutput("ovrDrained", word_valid, 0);

    driveBit(1'b1, 1'b1);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    checkOutput("abtQuiet", aborted, 0);
    data = 8'hF0;
    sbQueue.push_back({1'b0, data});
    driveBit(data[0], 1'b1);
    checkOutput("abtPulse", aborted, 1);
    driveBit(data[1], 1'b0);
    checkOutput("abtOneCycle", aborted, 0);
    for (int i = 2; i < N; i++) driveBit(data[i], 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
    driveBit(^data, 1'b0);
`endif
    checkOutput("abtValid", word_valid, 1);
    checkOutput("abtWord", word_out, 8'hF0);
    idleCycle();

    driveBit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) driveBit(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midRstWord", word_out, 0);
    checkOutput("midRstValid", word_valid, 0);
    checkOutput("midRstOverrun", overrun, 0);
    checkOutput("midRstAborted", aborted, 0);
    checkOutput("midRstParity", parity_err, 0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    reset = 1'b1;
    repeat (2) idleCycle();
    checkOutput("postRstValid", word_valid, 0);
    sbQueue.push_back({1'b0, 8'h11});
    sendFrame(8'h11, 0);
    checkOutput("postRstWord", word_out, 8'h11);
    checkOutput("postRstValid2", word_valid, 1);
    idleCycle();

`ifdef SERIAL_DESER_PARITY_EN
    sbQueue.push_back({1'b1, 8'hA5});
    sendDataBits(8'hA5, 0);
    driveBit(1'b1, 1'b0);
    checkOutput("parBadFlag", parity_err, 1);
    checkOutput("parBadWord", word_out, 8'hA5);
    idleCycle();
    sbQueue.push_back({1'b0, 8'hA5});
    sendDataBits(8'hA5, 0);
    driveBit(1'b0, 1'b0);
    checkOutput("parGoodFlag", parity_err, 0);
    checkOutput("parGoodValid", word_valid, 1);
    idleCycle();
`else
    checkOutput("parTied", parity_err, 0);
`endif

    repeat (3) idleCycle();
    checkOutput("sbDrained", sbQueue.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
SERIAL_WORD_DESERIALIZER -- requirements
Module: serial_word_deserializer

Interface
REQ-001 Parameter N, default 8, is the number of data bits per word and SHALL be at least 2.
REQ-002 Port clk, input, 1 bit: the clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port bit_in, input, 1 bit: the serial data bit, sampled only when bit_valid=1.
REQ-005 Port bit_valid, input, 1 bit: qualifies bit_in for the current cycle.
REQ-006 Port sof, input, 1 bit: start of frame; meaningful only when bit_valid=1, and marks bit_in as data bit 0.
REQ-007 Port word_out, output, N bits: the assembled word, with bit 0 being the first bit received.
REQ-008 Port word_valid, output, 1 bit: word_out (and parity_err) hold a word.
REQ-009 Port word_ready, input, 1 bit: the consumer accepts the word when word_valid=1 and word_ready=1 in the same cycle.
REQ-010 Port overrun, output, 1 bit: sticky flag indicating a completed word was dropped.
REQ-011 Port clr_overrun, input, 1 bit: synchronously clears overrun.
REQ-012 Port aborted, output, 1 bit: one-cycle pulse indicating a frame was restarted by sof.
REQ-013 Port parity_err, output, 1 bit: parity status qualified by word_valid.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only when PARITY_EN is defined.
REQ-015 In IDLE, bit_valid=1 with sof=0 SHALL be ignored; bit_valid=1 with sof=1 SHALL store the bit as bit 0, set the count to 1 and move to SHIFT.
REQ-016 In SHIFT, each bit_valid=1 with sof=0 SHALL store bit_in at index count and increment count; cycles with bit_valid=0 SHALL change nothing.
REQ-017 When the Nth data bit is accepted, the frame SHALL complete (PARITY_EN undefined) or the FSM SHALL go to PARITY (PARITY_EN defined).
REQ-018 On frame completion, if the output slot is free, or is freed in the same cycle (word_valid=1 and word_ready=1), the assembled word SHALL be loaded into word_out and word_valid SHALL be set.
REQ-019 Latency: word_valid SHALL be high in the first cycle after the cycle carrying the final bit.
REQ-020 If the slot is occupied and not accepted at completion, the new word SHALL be dropped, word_out SHALL keep the old word, and overrun SHALL be set.
REQ-021 After completion the FSM SHALL return to IDLE.
REQ-022 word_valid SHALL clear after acceptance unless a new word loads in the same cycle.
REQ-023 sof=1 with bit_valid=1 while in SHIFT or PARITY SHALL discard the partial frame, pulse aborted for one cycle, and restart with that bit as bit 0.
REQ-024 If clr_overrun and a new overrun event occur in the same cycle, set SHALL win.
REQ-025 word_out SHALL remain stable while word_valid=1 and word_ready=0.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, count 0, and word_out, word_valid, overrun, aborted and parity_err all to 0; any partial frame SHALL be lost.
REQ-027 No word SHALL be emitted from bits received before reset is released.

Configuration
REQ-028 Macro SERIAL_DESER_PARITY_EN defined: after N data bits, one additional bit SHALL be taken as an even-parity bit over the data, and parity_err SHALL be 1 with the word if the total number of ones is odd.
REQ-029 Macro SERIAL_DESER_PARITY_EN undefined: there SHALL be no PARITY state, and parity_err SHALL be tied to 0.

Structure
REQ-030 Package serial_deser_pkg SHALL hold the FSM state typedef and the default width constant.
REQ-031 Sub-module deser_bit_counter SHALL implement the bit index counter with load, increment and terminal-count functions; all other logic SHALL be in the top module.

Verification
REQ-032 The bench (N=8) SHALL send 0xA5 LSB-first, with sof on the first bit and word_ready=1: word_out=0xA5, and word_valid high for exactly 1 cycle, one cycle after bit 8.
REQ-033 The bench SHALL send 0x5A with random bit_valid gaps: word_out=0x5A, with latency still one cycle after the last valid bit.
REQ-034 The bench SHALL hold word_ready=0 and send 0x3C then 0x81: word_out stays 0x3C and overrun=1; then pulse clr_overrun: overrun=0, and word_ready=1 accepts 0x3C.
REQ-035 The bench SHALL assert sof after 3 bits of a frame, then send 0xF0: aborted pulses for 1 cycle, and word_out=0xF0.
REQ-036 The bench SHALL assert reset=0 after 5 bits: all outputs are 0 immediately, and after release a fresh 0x11 frame yields word_out=0x11.
REQ-037 With SERIAL_DESER_PARITY_EN defined, the bench SHALL send 0xA5 with parity bit 1 (parity_err=1) and 0xA5 with parity bit 0 (parity_err=0).
